axi_write_arbiter: RTL and testbench



---
 rtl/axi_write_arbiter_if.sv | 40 ++++
 rtl/axi_write_arbiter.sv | 163 ++++++++++++++++
 tb/tb_axi_write_arbiter.sv | 318 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_write_arbiter_if.sv
// rtl/axi_write_arbiter_if.sv - AXI4-Lite write-path bundle (AW, W, B) for N packed lanes
//
// Purpose: carries the write address, write data and write response
// channels for N lanes. Lane i owns bit i of each valid/ready, slice i of
// awaddr/wdata/wstrb and bits [2i+1:2i] of bresp.
//
// Signals:
//   awvalid/awready/awaddr   write address channel
//   wvalid/wready/wdata/wstrb write data channel
//   bvalid/bready/bresp      write response channel
// Modports:
//   master  drives AW/W payload, valids and bready
//   slave   drives awready/wready, bvalid and bresp
`timescale 1ns/1ps

interface axi_write_arbiter_if #(
  parameter int WIDTH = 32,
  parameter int N     = 1
) ();
  logic [N-1:0]           awvalid;
  logic [N-1:0]           awready;
  logic [N*WIDTH-1:0]     awaddr;
  logic [N-1:0]           wvalid;
  logic [N-1:0]           wready;
  logic [N*WIDTH-1:0]     wdata;
  logic [N*(WIDTH/8)-1:0] wstrb;
  logic [N-1:0]           bvalid;
  logic [N-1:0]           bready;
  logic [2*N-1:0]         bresp;

  modport master (
    output awvalid, awaddr, wvalid, wdata, wstrb, bready,
    input  awready, wready, bvalid, bresp
  );

  modport slave (
    input  awvalid, awaddr, wvalid, wdata, wstrb, bready,
    output awready, wready, bvalid, bresp
  );
endinterface

// File: rtl/axi_write_arbiter.sv
// rtl/axi_write_arbiter.sv - two-master to one-slave AXI4-Lite write arbiter
//
// Purpose: grants one complete write transaction (AW + W + B) at a time to
// one of two masters and routes the B response back to the granted master.
// Read channels are not handled here.
//
// Ports:
//   ACLK     clock, rising edge
//   ARESETn  asynchronous active-low reset
//   m        upstream bundle, two lanes (lane i = master i), slave modport
//   s        downstream bundle, one lane, master modport
//   grant    one-hot current owner, 00 when idle
//   busy     high while a transaction is in ADDR or RESP
//
// Configuration:
//   AXI_WARB_FIXED_PRIO_EN  defined: M0 always wins a simultaneous request.
//                           undefined: round-robin starting after the last
//                           served master.
`timescale 1ns/1ps

module axi_write_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic               ACLK,
  input  logic               ARESETn,
  axi_write_arbiter_if.slave  m,
  axi_write_arbiter_if.master s,
  output logic [1:0]         grant,
  output logic               busy
);

  localparam int SW = WIDTH / 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [1:0] grant_q, grant_d;
  logic [1:0] winner;
  logic       aw_done_q, aw_done_d;
  logic       w_done_q, w_done_d;
  logic       gidx;
  logic       aw_hs, w_hs, b_hs;
`ifndef AXI_WARB_FIXED_PRIO_EN
  logic       last_q, last_d;
`endif

  // grant is one-hot while busy, so bit 1 alone selects the lane
  assign gidx = grant_q[1];

  assign aw_hs = (state_q == ADDR) & m.awvalid[gidx] & ~aw_done_q & s.awready;
  assign w_hs  = (state_q == ADDR) & m.wvalid[gidx]  & ~w_done_q  & s.wready;
  assign b_hs  = (state_q == RESP) & s.bvalid & m.bready[gidx];

  // Arbitration looks at AW requests only
  always_comb begin
    winner = 2'b00;
`ifdef AXI_WARB_FIXED_PRIO_EN
    if (m.awvalid[0])      winner = 2'b01;
    else if (m.awvalid[1]) winner = 2'b10;
`else
    case (m.awvalid)
      2'b01:   winner = 2'b01;
      2'b10:   winner = 2'b10;
      2'b11:   winner = last_q ? 2'b01 : 2'b10;
      default: winner = 2'b00;
    endcase
`endif
  end

  // Payload muxes follow the registered grant; zero when nobody owns the bus
  assign s.awaddr = grant_q[1] ? m.awaddr[2*WIDTH-1:WIDTH] :
                    grant_q[0] ? m.awaddr[WIDTH-1:0]       : '0;
  assign s.wdata  = grant_q[1] ? m.wdata[2*WIDTH-1:WIDTH]  :
                    grant_q[0] ? m.wdata[WIDTH-1:0]        : '0;
  assign s.wstrb  = grant_q[1] ? m.wstrb[2*SW-1:SW]        :
                    grant_q[0] ? m.wstrb[SW-1:0]           : '0;

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
`ifndef AXI_WARB_FIXED_PRIO_EN
    last_d    = last_q;
`endif
    s.awvalid = 1'b0;
    s.wvalid  = 1'b0;
    s.bready  = 1'b0;
    m.awready = 2'b00;
    m.wready  = 2'b00;
    m.bvalid  = 2'b00;
    m.bresp   = 4'b0000;

    case (state_q)
      IDLE: begin
        if (|m.awvalid) begin
          grant_d   = winner;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = ADDR;
        end
      end

      ADDR: begin
        s.awvalid       = m.awvalid[gidx] & ~aw_done_q;
        s.wvalid        = m.wvalid[gidx]  & ~w_done_q;
        m.awready[gidx] = s.awready & ~aw_done_q;
        m.wready[gidx]  = s.wready  & ~w_done_q;
        aw_done_d       = aw_done_q | aw_hs;
        w_done_d        = w_done_q  | w_hs;
        // this cycle's handshakes count, so AW and W together take one cycle
        if (aw_done_d && w_done_d) state_d = RESP;
      end

      RESP: begin
        m.bvalid[gidx] = s.bvalid;
        s.bready       = m.bready[gidx];
        m.bresp        = gidx ? {s.bresp, 2'b00} : {2'b00, s.bresp};
        if (b_hs) begin
`ifndef AXI_WARB_FIXED_PRIO_EN
          last_d  = gidx;
`endif
          grant_d = 2'b00;
          state_d = IDLE;
        end
      end

      default: begin
        grant_d = 2'b00;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q   <= IDLE;
      grant_q   <= 2'b00;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
`ifndef AXI_WARB_FIXED_PRIO_EN
      // last = M1 so that M0 wins the first simultaneous request
      last_q    <= 1'b1;
`endif
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
`ifndef AXI_WARB_FIXED_PRIO_EN
      last_q    <= last_d;
`endif
    end
  end

  assign grant = grant_q;
  assign busy  = (state_q != IDLE);

endmodule

// File: tb/tb_axi_write_arbiter.sv
// tb/tb_axi_write_arbiter.sv - self-checking bench for axi_write_arbiter
`timescale 1ns/1ps

module tb_axi_write_arbiter;
  localparam int WIDTH = 32;
  localparam int SW    = WIDTH / 8;

  logic       ACLK    = 1'b0;
  logic       ARESETn = 1'b0;
  logic [1:0] grant;
  logic       busy;

  axi_write_arbiter_if #(.WIDTH(WIDTH), .N(2)) m_if ();
  axi_write_arbiter_if #(.WIDTH(WIDTH), .N(1)) s_if ();

  axi_write_arbiter #(.WIDTH(WIDTH)) dut (
    .ACLK    (ACLK),
    .ARESETn (ARESETn),
    .m       (m_if.slave),
    .s       (s_if.master),
    .grant   (grant),
    .busy    (busy)
  );

  always #5 ACLK = ~ACLK;

  typedef struct {
    int          mst;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [1:0]  bresp;
  } txn_t;

  txn_t sb[$];
  int   vectors = 0;
  int   errors  = 0;
  logic tb_last = 1'b1;

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic bus_clear();
    m_if.awvalid = 2'b00;
    m_if.awaddr  = '0;
    m_if.wvalid  = 2'b00;
    m_if.wdata   = '0;
    m_if.wstrb   = '0;
    m_if.bready  = 2'b00;
    s_if.awready = 1'b0;
    s_if.wready  = 1'b0;
    s_if.bvalid  = 1'b0;
    s_if.bresp   = 2'b00;
  endtask

  task automatic drive_master(input int i, input logic [31:0] addr, input logic [31:0] data,
                              input logic [3:0] strb);
    m_if.awaddr[i*WIDTH +: WIDTH] = addr;
    m_if.wdata[i*WIDTH +: WIDTH]  = data;
    m_if.wstrb[i*SW +: SW]        = strb;
  endtask

  // Reference arbitration: which master should win for a given request set
  function automatic int pick(input logic [1:0] req);
`ifdef AXI_WARB_FIXED_PRIO_EN
    return req[0] ? 0 : 1;
`else
    if (req == 2'b11) return tb_last ? 0 : 1;
    return req[1] ? 1 : 0;
`endif
  endfunction

  task automatic test_reset();
    bus_clear();
    ARESETn = 1'b0;
    tick();
    tick();
    vectors++; if (grant !== 2'b00) begin errors++; $display("FAIL reset_grant: got %b want 00", grant); end
    vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    vectors++; if ({s_if.awvalid, s_if.wvalid, s_if.bready} !== 3'b000) begin
      errors++; $display("FAIL reset_s_ctrl: got %b want 000", {s_if.awvalid, s_if.wvalid, s_if.bready}); end
    vectors++; if ({m_if.awready, m_if.wready, m_if.bvalid, m_if.bresp} !== 10'd0) begin
      errors++; $display("FAIL reset_m_ctrl: got %h want 000", {m_if.awready, m_if.wready, m_if.bvalid, m_if.bresp}); end
    ARESETn = 1'b1;
    tb_last = 1'b1;
    tick();
  endtask

  task automatic test_single_m0();
    txn_t t;
    bus_clear();
    t = '{mst: 0, addr: 32'h10, data: 32'hDEADBEEF, strb: 4'hF, bresp: 2'b00};
    drive_master(0, t.addr, t.data, t.strb);
    m_if.awvalid = 2'b01; m_if.wvalid = 2'b01; m_if.bready = 2'b01;
    s_if.awready = 1'b1;  s_if.wready = 1'b1;
    sb.push_back(t);
    #1;
    vectors++; if (s_if.awvalid !== 1'b0) begin errors++; $display("FAIL single_idle_awvalid: got %b want 0", s_if.awvalid); end
    tick();
    vectors++; if (grant !== 2'b01) begin errors++; $display("FAIL single_grant: got %b want 01", grant); end
    vectors++; if (s_if.awvalid !== 1'b1 || s_if.wvalid !== 1'b1) begin
      errors++; $display("FAIL single_s_valid: got %b%b want 11", s_if.awvalid, s_if.wvalid); end
    vectors++; if (s_if.awaddr !== sb[0].addr) begin errors++; $display("FAIL single_awaddr: got %h want %h", s_if.awaddr, sb[0].addr); end
    vectors++; if (s_if.wdata !== sb[0].data || s_if.wstrb !== sb[0].strb) begin
      errors++; $display("FAIL single_wdata: got %h/%h want %h/%h", s_if.wdata, s_if.wstrb, sb[0].data, sb[0].strb); end
    vectors++; if (m_if.awready !== 2'b01 || m_if.wready !== 2'b01) begin
      errors++; $display("FAIL single_m_ready: got %b/%b want 01/01", m_if.awready, m_if.wready); end
    tick();
    m_if.awvalid = 2'b00; m_if.wvalid = 2'b00;
    s_if.bvalid = 1'b1; s_if.bresp = 2'b00;
    #1;
    t = sb.pop_front();
    vectors++; if (m_if.bvalid !== (2'b01 << t.mst)) begin errors++; $display("FAIL single_bvalid: got %b want 01", m_if.bvalid); end
    vectors++; if (m_if.bresp !== ({2'b00, t.bresp} << (2*t.mst))) begin errors++; $display("FAIL single_bresp: got %b want 0000", m_if.bresp); end
    vectors++; if (s_if.bready !== 1'b1) begin errors++; $display("FAIL single_bready: got %b want 1", s_if.bready); end
    tb_last = t.mst[0];
    tick();
    s_if.bvalid = 1'b0;
    vectors++; if (grant !== 2'b00 || busy !== 1'b0) begin
      errors++; $display("FAIL single_back_idle: got grant=%b busy=%b want 00/0", grant, busy); end
    bus_clear();
  endtask

  // Both masters request every IDLE cycle; the loser keeps its request up
  task automatic test_simultaneous();
    logic [31:0] a [2];
    logic [31:0] d [2];
    txn_t t;
    int   w;
    bus_clear();
    ARESETn = 1'b0;
    tick();
    ARESETn = 1'b1;
    tb_last = 1'b1;
    for (int i = 0; i < 2; i++) begin
      a[i] = 32'h100 + 32'h40 * i;
      d[i] = 32'hA000_0000 + 32'h0001_0000 * i;
      drive_master(i, a[i], d[i], 4'hF);
    end
    m_if.awvalid = 2'b11; m_if.wvalid = 2'b11; m_if.bready = 2'b11;
    s_if.awready = 1'b1;  s_if.wready = 1'b1;
    for (int r = 0; r < 4; r++) begin
      w = pick(2'b11);
      t = '{mst: w, addr: a[w], data: d[w], strb: 4'hF, bresp: r[1:0]};
      sb.push_back(t);
      #1;
      vectors++; if (grant !== 2'b00 || busy !== 1'b0) begin
        errors++; $display("FAIL sim_idle_r%0d: got grant=%b busy=%b want 00/0", r, grant, busy); end
      tick();
      vectors++; if (grant !== (2'b01 << sb[0].mst)) begin
        errors++; $display("FAIL sim_grant_r%0d: got %b want %b", r, grant, 2'b01 << sb[0].mst); end
      vectors++; if (s_if.awaddr !== sb[0].addr || s_if.wdata !== sb[0].data) begin
        errors++; $display("FAIL sim_payload_r%0d: got %h/%h want %h/%h", r, s_if.awaddr, s_if.wdata, sb[0].addr, sb[0].data); end
      vectors++; if (m_if.awready !== (2'b01 << sb[0].mst)) begin
        errors++; $display("FAIL sim_awready_r%0d: got %b want %b", r, m_if.awready, 2'b01 << sb[0].mst); end
      tick();
      m_if.awvalid[w] = 1'b0; m_if.wvalid[w] = 1'b0;
      s_if.bvalid = 1'b1; s_if.bresp = sb[0].bresp;
      #1;
      t = sb.pop_front();
      vectors++; if (m_if.bvalid !== (2'b01 << t.mst)) begin
        errors++; $display("FAIL sim_bvalid_r%0d: got %b want %b", r, m_if.bvalid, 2'b01 << t.mst); end
      vectors++; if (m_if.bresp !== ({2'b00, t.bresp} << (2*t.mst))) begin
        errors++; $display("FAIL sim_bresp_r%0d: got %b want %b", r, m_if.bresp, {2'b00, t.bresp} << (2*t.mst)); end
      tb_last = t.mst[0];
      tick();
      s_if.bvalid = 1'b0;
      a[w] = a[w] + 32'h4;
      d[w] = d[w] + 32'h1;
      drive_master(w, a[w], d[w], 4'hF);
      m_if.awvalid[w] = 1'b1; m_if.wvalid[w] = 1'b1;
    end
    bus_clear();
    tick();
  endtask

  task automatic test_w_before_aw();
    txn_t t;
    int   pulses = 0;
    bus_clear();
    t = '{mst: 1, addr: 32'h200, data: 32'h1234_5678, strb: 4'h3, bresp: 2'b00};
    drive_master(1, t.addr, t.data, t.strb);
    m_if.wvalid = 2'b10; m_if.bready = 2'b10;
    s_if.wready = 1'b1;  s_if.bvalid = 1'b1; s_if.bresp = t.bresp;
    for (int k = 0; k < 2; k++) begin
      #1;
      if (m_if.wready[1]) pulses++;
      vectors++; if (grant !== 2'b00 || m_if.wready !== 2'b00) begin
        errors++; $display("FAIL wfirst_idle_k%0d: got grant=%b wready=%b want 00/00", k, grant, m_if.wready); end
      tick();
    end
    m_if.awvalid = 2'b10;
    sb.push_back(t);
    #1;
    tick();
    for (int k = 0; k < 4; k++) begin
      s_if.awready = (k == 3);
      #1;
      if (m_if.wready[1]) pulses++;
      vectors++; if (busy !== 1'b1 || grant !== 2'b10 || m_if.bvalid !== 2'b00) begin
        errors++; $display("FAIL wfirst_addr_k%0d: got busy=%b grant=%b bvalid=%b want 1/10/00", k, busy, grant, m_if.bvalid); end
      vectors++; if (s_if.wvalid !== (k == 0)) begin
        errors++; $display("FAIL wfirst_swvalid_k%0d: got %b want %b", k, s_if.wvalid, k == 0); end
      if (k == 0) begin
        vectors++; if (s_if.wdata !== sb[0].data || s_if.wstrb !== sb[0].strb) begin
          errors++; $display("FAIL wfirst_wdata: got %h/%h want %h/%h", s_if.wdata, s_if.wstrb, sb[0].data, sb[0].strb); end
      end
      if (k == 3) begin
        vectors++; if (s_if.awaddr !== sb[0].addr || m_if.awready !== 2'b10) begin
          errors++; $display("FAIL wfirst_aw: got %h/%b want %h/10", s_if.awaddr, m_if.awready, sb[0].addr); end
      end
      tick();
    end
    m_if.awvalid = 2'b00; m_if.wvalid = 2'b00; s_if.awready = 1'b0;
    #1;
    t = sb.pop_front();
    vectors++; if (m_if.bvalid !== 2'b10 || m_if.bresp !== {t.bresp, 2'b00}) begin
      errors++; $display("FAIL wfirst_resp: got %b/%b want 10/%b", m_if.bvalid, m_if.bresp, {t.bresp, 2'b00}); end
    vectors++; if (pulses !== 1) begin errors++; $display("FAIL wfirst_wready_pulses: got %0d want 1", pulses); end
    tb_last = 1'b1;
    tick();
    s_if.bvalid = 1'b0;
    vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL wfirst_idle: got busy=%b want 0", busy); end
    bus_clear();
  endtask

  task automatic test_error_resp();
    txn_t t;
    bus_clear();
    t = '{mst: 1, addr: 32'h300, data: 32'hCAFE_F00D, strb: 4'hF, bresp: 2'b10};
    drive_master(1, t.addr, t.data, t.strb);
    m_if.awvalid = 2'b10; m_if.wvalid = 2'b10;
    s_if.awready = 1'b1;  s_if.wready = 1'b1;
    sb.push_back(t);
    #1;
    tick();
    vectors++; if (grant !== 2'b10) begin errors++; $display("FAIL err_grant: got %b want 10", grant); end
    tick();
    m_if.awvalid = 2'b00; m_if.wvalid = 2'b00;
    s_if.bvalid = 1'b1; s_if.bresp = sb[0].bresp; m_if.bready = 2'b00;
    for (int k = 0; k < 4; k++) begin
      #1;
      vectors++; if (m_if.bvalid !== 2'b10 || m_if.bresp !== {sb[0].bresp, 2'b00} || s_if.bready !== 1'b0 || busy !== 1'b1) begin
        errors++; $display("FAIL err_hold_k%0d: got bvalid=%b bresp=%b bready=%b busy=%b want 10/%b/0/1",
                           k, m_if.bvalid, m_if.bresp, s_if.bready, busy, {sb[0].bresp, 2'b00}); end
      tick();
    end
    m_if.bready = 2'b10;
    #1;
    t = sb.pop_front();
    vectors++; if (s_if.bready !== 1'b1 || m_if.bresp !== {t.bresp, 2'b00}) begin
      errors++; $display("FAIL err_accept: got bready=%b bresp=%b want 1/%b", s_if.bready, m_if.bresp, {t.bresp, 2'b00}); end
    tb_last = 1'b1;
    tick();
    s_if.bvalid = 1'b0;
    vectors++; if (busy !== 1'b0 || grant !== 2'b00) begin
      errors++; $display("FAIL err_idle: got busy=%b grant=%b want 0/00", busy, grant); end
    bus_clear();
  endtask

  task automatic test_reset_mid();
    txn_t t;
    bus_clear();
    drive_master(1, 32'h400, 32'h5555_AAAA, 4'hF);
    m_if.awvalid = 2'b10; m_if.wvalid = 2'b10;
    #1;
    tick();
    vectors++; if (s_if.awvalid !== 1'b1) begin errors++; $display("FAIL rmid_pre_awvalid: got %b want 1", s_if.awvalid); end
    ARESETn = 1'b0;
    #1;
    vectors++; if (grant !== 2'b00 || busy !== 1'b0 || s_if.awvalid !== 1'b0) begin
      errors++; $display("FAIL rmid_async: got grant=%b busy=%b awvalid=%b want 00/0/0", grant, busy, s_if.awvalid); end
    tick();
    ARESETn = 1'b1;
    tb_last = 1'b1;
    t = '{mst: pick(2'b11), addr: 32'h500, data: 32'h0BAD_C0DE, strb: 4'hF, bresp: 2'b01};
    drive_master(0, 32'h500, 32'h0BAD_C0DE, 4'hF);
    m_if.awvalid = 2'b11; m_if.wvalid = 2'b11; m_if.bready = 2'b11;
    s_if.awready = 1'b1;  s_if.wready = 1'b1;
    sb.push_back(t);
    #1;
    tick();
    vectors++; if (grant !== (2'b01 << sb[0].mst) || s_if.awaddr !== sb[0].addr) begin
      errors++; $display("FAIL rmid_regrant: got grant=%b awaddr=%h want %b/%h", grant, s_if.awaddr, 2'b01 << sb[0].mst, sb[0].addr); end
    tick();
    m_if.awvalid = 2'b00; m_if.wvalid = 2'b00;
    s_if.bvalid = 1'b1; s_if.bresp = sb[0].bresp;
    #1;
    t = sb.pop_front();
    vectors++; if (m_if.bvalid !== (2'b01 << t.mst) || m_if.bresp !== ({2'b00, t.bresp} << (2*t.mst))) begin
      errors++; $display("FAIL rmid_resp: got %b/%b want %b/%b", m_if.bvalid, m_if.bresp, 2'b01 << t.mst, {2'b00, t.bresp} << (2*t.mst)); end
    tick();
    bus_clear();
    tick();
  endtask

  initial begin
    bus_clear();
    test_reset();
    test_single_m0();
    test_simultaneous();
    test_w_before_aw();
    test_error_resp();
    test_reset_mid();
    vectors++; if (sb.size() != 0) begin errors++; $display("FAIL scoreboard_drain: got %0d left want 0", sb.size()); end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
